// File: rtl/ff1_rr_dispatch_pkg.sv
// rtl/ff1_rr_dispatch_pkg.sv - shared constants and mode type for the ff1 dispatcher
package ff1_disp_pkg;

  // Largest supported number of event lines; sizes the search's internal position math.
  localparam int MAX_WIDTH = 256;

  // Selection mode: lowest index first, or scan from the round-robin pointer.
  typedef enum logic {
    FIXED = 1'b0,
    RR    = 1'b1
  } ff1_mode_e;

endpackage

// File: rtl/ff1_rr_dispatch_if.sv
// rtl/ff1_rr_dispatch_if.sv - valid/ready index offer from dispatcher to consumer
interface ff1_rr_dispatch_if #(
  parameter int IDX_W = 5
);

  logic             valid;
  logic [IDX_W-1:0] idx;
  logic             ready;

  modport master (output valid, output idx, input ready);
  modport slave  (input valid, input idx, output ready);

endinterface

// File: rtl/ff1_rr_dispatch_rot_search.sv
// rtl/ff1_rr_dispatch_rot_search.sv - combinational find-first-one from a start index with wrap
module ff1_rot_search
  import ff1_disp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vector,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             none
);

  // Wide enough to hold start + offset for any legal WIDTH before folding back.
  localparam int POS_W = $clog2(MAX_WIDTH) + 1;

  logic [POS_W-1:0] pos;

  // Walk offsets 0..WIDTH-1 from start, folding positions modulo WIDTH; first hit wins.
  always_comb begin
    idx  = '0;
    none = 1'b1;
    pos  = '0;
    for (int k = 0; k < WIDTH; k++) begin
      pos = POS_W'(start) + POS_W'(k);
      if (pos >= POS_W'(WIDTH)) begin
        pos = pos - POS_W'(WIDTH);
      end
      if (none && vector[pos[IDX_W-1:0]]) begin
        idx  = pos[IDX_W-1:0];
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ff1_rr_dispatch.sv
// rtl/ff1_rr_dispatch.sv - sticky pending register with fixed/round-robin index offer (option: FF1_DISP_MASK_EN)
module ff1_rr_dispatch
  import ff1_disp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] evt_i,
  input  logic [WIDTH-1:0] clr_i,
  input  logic             rr_en_i,
`ifdef FF1_DISP_MASK_EN
  input  logic [WIDTH-1:0] mask_i,
`endif
  output logic [WIDTH-1:0] pend_o,
  ff1_rr_dispatch_if.master disp
);

  localparam int IDX_W = $clog2(WIDTH);

  logic [WIDTH-1:0] pend_q, pend_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] line_en;
  logic [WIDTH-1:0] acc_vec;
  logic [WIDTH-1:0] srch_vec;
  logic [IDX_W-1:0] srch_start;
  logic [IDX_W-1:0] srch_idx;
  logic             srch_none;
  logic             accept;
  ff1_mode_e        mode;

`ifdef FF1_DISP_MASK_EN
  assign line_en = mask_i;
`else
  assign line_en = '1;
`endif

  assign mode   = ff1_mode_e'(rr_en_i);
  assign accept = valid_q && disp.ready;

  // One-hot of the line being accepted this cycle.
  always_comb begin
    acc_vec = '0;
    if (accept) begin
      acc_vec[idx_q] = 1'b1;
    end
  end

  // Search the current pending set, excluding the line accepted now and lines being cleared now,
  // so the next offer never names a bit that is about to disappear.
  assign srch_vec   = pend_q & line_en & ~clr_i & ~acc_vec;
  assign srch_start = (mode == RR) ? ptr_q : '0;

  ff1_rot_search #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_search (
    .vector (srch_vec),
    .start  (srch_start),
    .idx    (srch_idx),
    .none   (srch_none)
  );

  // Pending update, pointer advance and offer register load/hold/withdraw.
  always_comb begin
    pend_d  = (pend_q & ~clr_i & ~acc_vec) | evt_i;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    idx_d   = idx_q;

    if (accept && (mode == RR)) begin
      ptr_d = (idx_q == IDX_W'(WIDTH - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    if (!valid_q || disp.ready) begin
      valid_d = !srch_none;
      if (!srch_none) begin
        idx_d = srch_idx;
      end
    end else if (!pend_d[idx_q] || !line_en[idx_q]) begin
      // Held line vanished (cleared or masked): withdraw rather than offer a dead index.
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; events in the reset cycle are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q  <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign pend_o     = pend_q;
  assign disp.valid = valid_q;
  assign disp.idx   = idx_q;

endmodule
